lii_rx_endpoint: RTL and testbench

Receive-side endpoint of the LII phy link. It accepts PW-bit LII beats, keeps only those addressed to this node (`LOCAL_ID` or broadcast), and buffers the low DW bits of each accepted beat in a small first-word-fall-through FIFO. It presents them as an AXI-Stream-style kernel input stream. It sits between the LII fabric and an HLS kernel's input stream: it is the consumer of what a kernel wrapper's packed `lii_out_p0_*` produces, with decoupling and address filtering that a combinational unpack does not provide.

---
 rtl/lii_rx_endpoint_if.sv | 31 +++
 rtl/lii_rx_endpoint.sv | 111 +++++++++++
 tb/tb_lii_rx_endpoint.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lii_rx_endpoint_if.sv
// Bundles the LII receive beat channel and the kernel input stream of the endpoint.
// The master side drives beats and consumes the stream; the slave side is the endpoint.
interface lii_rx_endpoint_if #(
  parameter int PW = 1024,
  parameter int DW = 384
);
  logic [PW-1:0] lii_in_p0_tdata;
  logic          lii_in_p0_tvalid;
  logic          lii_in_p0_tready;
  logic [7:0]    lii_in_p0_src;
  logic [7:0]    lii_in_p0_dst;

  logic [DW-1:0] in_stream_tdata;
  logic          in_stream_tvalid;
  logic          in_stream_tready;
  logic [7:0]    in_stream_src;

  modport master (
    output lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst,
    input  lii_in_p0_tready,
    input  in_stream_tdata, in_stream_tvalid, in_stream_src,
    output in_stream_tready
  );

  modport slave (
    input  lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst,
    output lii_in_p0_tready,
    output in_stream_tdata, in_stream_tvalid, in_stream_src,
    input  in_stream_tready
  );
endinterface

// File: rtl/lii_rx_endpoint.sv
// LII receive endpoint: filters beats by destination id and buffers the low DW bits
// plus source id in a first-word-fall-through FIFO feeding a kernel input stream.
module lii_rx_endpoint #(
  parameter int         PW           = 1024,
  parameter int         DW           = 384,
  parameter int         DEPTH        = 4,
  parameter logic [7:0] LOCAL_ID     = 8'h00,
  parameter bit         ACCEPT_BCAST = 1'b1
) (
  input  logic                     aclk,
  input  logic                     arstn,
  lii_rx_endpoint_if.slave         bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt,
  output logic                     ce
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DW + 8;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   drop_q, drop_d;
  logic          live_q, live_d;

  logic match_s, tready_s, hs_s, wr_s, drop_s, pop_s, tvalid_s;

  generate
    if (PW > DW) begin : g_unused_hi
      logic unused_hi_s;
      assign unused_hi_s = ^bus.lii_in_p0_tdata[PW-1:DW];
    end
  endgenerate

  // Handshake decode and next-state computation for pointers, occupancy and drop counter.
  always_comb begin
    match_s  = (bus.lii_in_p0_dst == LOCAL_ID) |
               (ACCEPT_BCAST && (bus.lii_in_p0_dst == 8'hFF));
    // Ready depends only on registered state, so there is no input-to-ready path.
    tready_s = live_q & (level_q != LW'(DEPTH));
    tvalid_s = (level_q != {LW{1'b0}});
    hs_s     = bus.lii_in_p0_tvalid & tready_s;
    wr_s     = hs_s & match_s;
    drop_s   = hs_s & ~match_s;
    pop_s    = tvalid_s & bus.in_stream_tready;

    live_d   = 1'b1;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;

    if (wr_s) begin
      mem_d[wr_ptr_q] = {bus.lii_in_p0_src, bus.lii_in_p0_tdata[DW-1:0]};
      wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers; reset clears storage so the head reads as zero when idle.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      drop_q   <= 16'h0000;
      live_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      live_q   <= live_d;
    end
  end

  assign bus.lii_in_p0_tready = tready_s;
  assign bus.in_stream_tvalid = tvalid_s;
  assign bus.in_stream_tdata  = mem_q[rd_ptr_q][DW-1:0];
  assign bus.in_stream_src    = mem_q[rd_ptr_q][EW-1:DW];
  assign level                = level_q;
  assign drop_cnt             = drop_q;
  assign ce                   = tvalid_s;
endmodule

// File: tb/tb_lii_rx_endpoint.sv
// Directed bench for lii_rx_endpoint: two instances (broadcast accepted / rejected)
// share one stimulus stream; a stream monitor collects delivered beats for ordering.
module tb_lii_rx_endpoint;
  logic          aclk;
  logic          arstn;
  logic [1023:0] td;
  logic          tv;
  logic [7:0]    sr;
  logic [7:0]    ds;
  logic          kr;

  logic [2:0]  level_a, level_b;
  logic [15:0] drop_a, drop_b;
  logic        ce_a, ce_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rx_b    = 0;

  logic [391:0] expq[$];
  logic [391:0] rxq[$];

  lii_rx_endpoint_if #(.PW(1024), .DW(384)) bus_a ();
  lii_rx_endpoint_if #(.PW(1024), .DW(384)) bus_b ();

  assign bus_a.lii_in_p0_tdata  = td;
  assign bus_a.lii_in_p0_tvalid = tv;
  assign bus_a.lii_in_p0_src    = sr;
  assign bus_a.lii_in_p0_dst    = ds;
  assign bus_a.in_stream_tready = kr;
  assign bus_b.lii_in_p0_tdata  = td;
  assign bus_b.lii_in_p0_tvalid = tv;
  assign bus_b.lii_in_p0_src    = sr;
  assign bus_b.lii_in_p0_dst    = ds;
  assign bus_b.in_stream_tready = kr;

  lii_rx_endpoint #(.PW(1024), .DW(384), .DEPTH(4), .LOCAL_ID(8'h05), .ACCEPT_BCAST(1'b1)) dut_a (
    .aclk(aclk), .arstn(arstn), .bus(bus_a), .level(level_a), .drop_cnt(drop_a), .ce(ce_a)
  );
  lii_rx_endpoint #(.PW(1024), .DW(384), .DEPTH(4), .LOCAL_ID(8'h05), .ACCEPT_BCAST(1'b0)) dut_b (
    .aclk(aclk), .arstn(arstn), .bus(bus_b), .level(level_b), .drop_cnt(drop_b), .ce(ce_b)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Record every kernel pop; inputs are stable between negedge and the next posedge.
  always @(negedge aclk) begin
    if (arstn && kr && bus_a.in_stream_tvalid) rxq.push_back({bus_a.in_stream_src, bus_a.in_stream_tdata});
    if (arstn && kr && bus_b.in_stream_tvalid) rx_b++;
  end

  function automatic logic [1023:0] rnd();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [7:0] s, input logic [7:0] d, input logic [1023:0] data);
    td = data;
    tv = 1'b1;
    sr = s;
    ds = d;
    if (d == 8'h05 || d == 8'hFF) expq.push_back({s, data[383:0]});
  endtask

  task automatic wait_hs();
    bit hs;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk);
      hs = bus_a.lii_in_p0_tready;
      @(posedge aclk);
      #1;
    end
    tv = 1'b0;
    vec_cnt++;
    if (!hs) begin
      err_cnt++;
      $display("FAIL hs_timeout: handshake not seen within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && level_a != 3'd0; i++) step();
    vec_cnt++;
    if (level_a !== 3'd0) begin
      err_cnt++;
      $display("FAIL drain_timeout: level=%0d required 0", level_a);
    end
  endtask

  task automatic check_stream(input string name);
    vec_cnt++;
    if (rxq.size() != expq.size()) begin
      err_cnt++;
      $display("FAIL %s_count: got %0d beats required %0d", name, rxq.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        vec_cnt++;
        if (rxq[i] !== expq[i]) begin
          err_cnt++;
          $display("FAIL %s_beat%0d: got src %h required src %h (data differs=%0d)", name, i,
                   rxq[i][391:384], expq[i][391:384], rxq[i][383:0] !== expq[i][383:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    arstn = 1'b1; tv = 1'b0; td = '0; sr = 8'h00; ds = 8'h00; kr = 1'b0;
    #2 arstn = 1'b0;
    step();
    step();
    vec_cnt++;
    if (bus_a.lii_in_p0_tready !== 1'b0) begin err_cnt++; $display("FAIL rst_tready_low: got %b required 0", bus_a.lii_in_p0_tready); end
    @(negedge aclk);
    arstn = 1'b1;
    step();
    vec_cnt++;
    if (bus_a.lii_in_p0_tready !== 1'b1) begin err_cnt++; $display("FAIL rst_tready_up: got %b required 1", bus_a.lii_in_p0_tready); end
    vec_cnt++;
    if (bus_a.in_stream_tvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_tvalid: got %b required 0", bus_a.in_stream_tvalid); end
    vec_cnt++;
    if (level_a !== 3'd0) begin err_cnt++; $display("FAIL rst_level: got %0d required 0", level_a); end
    vec_cnt++;
    if (drop_a !== 16'h0000) begin err_cnt++; $display("FAIL rst_drop: got %h required 0000", drop_a); end
    vec_cnt++;
    if (ce_a !== 1'b0) begin err_cnt++; $display("FAIL rst_ce: got %b required 0", ce_a); end
    vec_cnt++;
    if (bus_a.in_stream_tdata !== 384'd0 || bus_a.in_stream_src !== 8'h00) begin
      err_cnt++; $display("FAIL rst_head: src %h required 00, data nonzero=%0d", bus_a.in_stream_src, |bus_a.in_stream_tdata);
    end
  endtask

  task automatic test_basic();
    logic [1023:0] d;
    expq.delete(); rxq.delete();
    kr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = rnd();
      drive(8'(i + 1), 8'h05, d);
      wait_hs();
      vec_cnt++;
      if (bus_a.in_stream_tvalid !== 1'b1) begin err_cnt++; $display("FAIL basic_tvalid%0d: got %b required 1", i, bus_a.in_stream_tvalid); end
      vec_cnt++;
      if (bus_a.in_stream_src !== 8'(i + 1)) begin err_cnt++; $display("FAIL basic_src%0d: got %h required %h", i, bus_a.in_stream_src, 8'(i + 1)); end
      vec_cnt++;
      if (bus_a.in_stream_tdata !== d[383:0]) begin err_cnt++; $display("FAIL basic_data%0d: got %h required %h", i, bus_a.in_stream_tdata, d[383:0]); end
    end
    step();
    vec_cnt++;
    if (bus_a.in_stream_tvalid !== 1'b0 || ce_a !== 1'b0) begin
      err_cnt++; $display("FAIL basic_empty: tvalid %b ce %b required 0 0", bus_a.in_stream_tvalid, ce_a);
    end
    check_stream("basic");
  endtask

  task automatic test_filter();
    logic [7:0] dl [4];
    dl[0] = 8'h05; dl[1] = 8'h07; dl[2] = 8'hFF; dl[3] = 8'h07;
    expq.delete(); rxq.delete(); rx_b = 0;
    kr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'(8'h10 + i), dl[i], rnd());
      wait_hs();
    end
    step();
    step();
    vec_cnt++;
    if (drop_a !== 16'd2) begin err_cnt++; $display("FAIL filter_drop_bcast: got %0d required 2", drop_a); end
    vec_cnt++;
    if (drop_b !== 16'd3) begin err_cnt++; $display("FAIL filter_drop_nobcast: got %0d required 3", drop_b); end
    vec_cnt++;
    if (rx_b !== 1) begin err_cnt++; $display("FAIL filter_rx_nobcast: got %0d required 1", rx_b); end
    check_stream("filter");
  endtask

  task automatic test_full();
    expq.delete(); rxq.delete();
    kr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(8'h20 + i), 8'h05, rnd());
      wait_hs();
    end
    vec_cnt++;
    if (level_a !== 3'd4) begin err_cnt++; $display("FAIL full_level: got %0d required 4", level_a); end
    vec_cnt++;
    if (bus_a.lii_in_p0_tready !== 1'b0) begin err_cnt++; $display("FAIL full_tready: got %b required 0", bus_a.lii_in_p0_tready); end
    vec_cnt++;
    if (ce_a !== 1'b1) begin err_cnt++; $display("FAIL full_ce: got %b required 1", ce_a); end
    drive(8'h24, 8'h05, rnd());
    step(); step(); step();
    vec_cnt++;
    if (level_a !== 3'd4) begin err_cnt++; $display("FAIL full_stall_level: got %0d required 4", level_a); end
    kr = 1'b1;
    step();
    vec_cnt++;
    if (bus_a.lii_in_p0_tready !== 1'b1) begin err_cnt++; $display("FAIL full_reopen: got %b required 1", bus_a.lii_in_p0_tready); end
    vec_cnt++;
    if (level_a !== 3'd3) begin err_cnt++; $display("FAIL full_after_pop: got %0d required 3", level_a); end
    wait_hs();
    drive(8'h25, 8'h05, rnd());
    wait_hs();
    drain();
    check_stream("full");
  endtask

  task automatic test_wrap();
    expq.delete(); rxq.delete();
    kr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(8'(8'h30 + i), 8'h05, rnd());
      wait_hs();
    end
    kr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(8'(8'h40 + i), 8'h05, rnd());
      step();
      vec_cnt++;
      if (level_a !== 3'd2) begin err_cnt++; $display("FAIL wrap_level%0d: got %0d required 2", i, level_a); end
    end
    tv = 1'b0;
    drain();
    check_stream("wrap");
  endtask

  task automatic test_reset_mid();
    logic [1023:0] d;
    expq.delete(); rxq.delete();
    kr = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(8'(8'h50 + i), 8'h05, rnd()); wait_hs(); end
    for (int i = 0; i < 7; i++) begin drive(8'(8'h60 + i), 8'h07, rnd()); wait_hs(); end
    vec_cnt++;
    if (level_a !== 3'd3) begin err_cnt++; $display("FAIL mid_pre_level: got %0d required 3", level_a); end
    vec_cnt++;
    if (drop_a !== 16'd9) begin err_cnt++; $display("FAIL mid_pre_drop: got %0d required 9", drop_a); end
    arstn = 1'b0;
    #2;
    vec_cnt++;
    if (level_a !== 3'd0 || drop_a !== 16'd0) begin err_cnt++; $display("FAIL mid_async_clear: level %0d drop %0d required 0 0", level_a, drop_a); end
    vec_cnt++;
    if (bus_a.in_stream_tvalid !== 1'b0 || ce_a !== 1'b0 || bus_a.lii_in_p0_tready !== 1'b0) begin
      err_cnt++; $display("FAIL mid_async_ctrl: tvalid %b ce %b tready %b required 0 0 0", bus_a.in_stream_tvalid, ce_a, bus_a.lii_in_p0_tready);
    end
    vec_cnt++;
    if (bus_a.in_stream_tdata !== 384'd0 || bus_a.in_stream_src !== 8'h00) begin
      err_cnt++; $display("FAIL mid_async_head: src %h required 00, data nonzero=%0d", bus_a.in_stream_src, |bus_a.in_stream_tdata);
    end
    @(negedge aclk);
    arstn = 1'b1;
    step();
    expq.delete(); rxq.delete();
    vec_cnt++;
    if (bus_a.lii_in_p0_tready !== 1'b1 || level_a !== 3'd0) begin
      err_cnt++; $display("FAIL mid_release: tready %b level %0d required 1 0", bus_a.lii_in_p0_tready, level_a);
    end
    kr = 1'b1;
    d = rnd();
    drive(8'h77, 8'h05, d);
    wait_hs();
    vec_cnt++;
    if (bus_a.in_stream_tvalid !== 1'b1 || bus_a.in_stream_src !== 8'h77 || bus_a.in_stream_tdata !== d[383:0]) begin
      err_cnt++; $display("FAIL mid_new_beat: tvalid %b src %h required 1 77", bus_a.in_stream_tvalid, bus_a.in_stream_src);
    end
    step();
    check_stream("mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
